// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU / debug) shared RAM bus arbiter and IDLE->ACC->RESP access sequencer.
// Optional MEM_ARB_RANGE_CHECK_EN blocks accesses with the address MSB set and flags debug errors.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_BURST  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ack,
   output logic                  cpu_stall,
   input  logic                  dbg_req,
   input  logic                  dbg_we,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  dbg_ack,
   output logic                  dbg_err,
   input  logic                  dbg_hold,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  mem_oe,
   output logic                  mem_we
);

   localparam int unsigned BURST_W = 4;
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;   // 1 = debug master owns the access
   logic                  we_q, we_d;
   logic                  oor_q, oor_d;
   logic [BURST_W-1:0]    burst_q, burst_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
   logic                  mem_oe_q, mem_oe_d;
   logic                  mem_we_q, mem_we_d;
   logic                  cpu_ack_q, cpu_ack_d;
   logic                  dbg_ack_q, dbg_ack_d;
   logic                  dbg_err_q, dbg_err_d;
   logic                  cpu_stall_q, cpu_stall_d;

   logic                  dbg_win;
   logic                  win_we;
   logic                  win_oor;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_wdata;

   // Debug wins unless the CPU is waiting and debug has used up its burst allowance.
   assign dbg_win   = dbg_req && (!cpu_req || (burst_q != BURST_MAX));
   assign win_we    = dbg_win ? dbg_we    : cpu_we;
   assign win_addr  = dbg_win ? dbg_addr  : cpu_addr;
   assign win_wdata = dbg_win ? dbg_wdata : cpu_wdata;

`ifdef MEM_ARB_RANGE_CHECK_EN
   assign win_oor = win_addr[ADDR_WIDTH-1];
`else
   assign win_oor = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      oor_d       = oor_q;
      burst_d     = burst_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      dbg_rdata_d = dbg_rdata_q;
      mem_oe_d    = 1'b0;
      mem_we_d    = 1'b0;
      cpu_ack_d   = 1'b0;
      dbg_ack_d   = 1'b0;
      dbg_err_d   = 1'b0;
      cpu_stall_d = dbg_hold;

      case (state_q)
         IDLE: begin
            if (dbg_win) begin
               burst_d = (burst_q == BURST_MAX) ? burst_q : burst_q + BURST_W'(1);
            end else begin
               burst_d = '0;
            end
            if (dbg_req || cpu_req) begin
               state_d     = ACC;
               owner_d     = dbg_win;
               we_d        = win_we;
               oor_d       = win_oor;
               mem_addr_d  = win_addr;
               mem_wdata_d = win_wdata;
               mem_oe_d    = !win_we && !win_oor;
               mem_we_d    = win_we && !win_oor;
            end
         end
         ACC: begin
            state_d   = RESP;
            cpu_ack_d = !owner_q;
            dbg_ack_d = owner_q;
            dbg_err_d = owner_q && oor_q;
            // Blocked reads return zero rather than whatever is on the RAM data bus.
            if (!we_q) begin
               if (owner_q) begin
                  dbg_rdata_d = oor_q ? '0 : mem_rdata;
               end else begin
                  cpu_rdata_d = oor_q ? '0 : mem_rdata;
               end
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         oor_q       <= 1'b0;
         burst_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rdata_q <= '0;
         dbg_rdata_q <= '0;
         mem_oe_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dbg_ack_q   <= 1'b0;
         dbg_err_q   <= 1'b0;
         cpu_stall_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         oor_q       <= oor_d;
         burst_q     <= burst_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         dbg_rdata_q <= dbg_rdata_d;
         mem_oe_q    <= mem_oe_d;
         mem_we_q    <= mem_we_d;
         cpu_ack_q   <= cpu_ack_d;
         dbg_ack_q   <= dbg_ack_d;
         dbg_err_q   <= dbg_err_d;
         cpu_stall_q <= cpu_stall_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_oe    = mem_oe_q;
   assign mem_we    = mem_we_q;
   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign cpu_stall = cpu_stall_q;
   assign dbg_rdata = dbg_rdata_q;
   assign dbg_ack   = dbg_ack_q;
   assign dbg_err   = dbg_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboarded bench for mem_bus_arbiter: directed timing cases plus randomized two-master traffic
// against a RAM model and a shadow-memory reference.
module tb_mem_bus_arbiter;

   localparam int unsigned AW   = 16;
   localparam int unsigned DW   = 8;
   localparam int unsigned MAXB = 4;
`ifdef MEM_ARB_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack, cpu_stall;
   logic          dbg_req = 1'b0, dbg_we = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic [DW-1:0] dbg_wdata = '0;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_ack, dbg_err;
   logic          dbg_hold = 1'b0;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_oe, mem_we;

   int n_checks = 0;
   int n_fail   = 0;

   mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_hold(dbg_hold),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_oe(mem_oe), .mem_we(mem_we)
   );

   always #5 clk = ~clk;

   // RAM device: combinational read, write on the clock edge; backdoor port for preload.
   logic [7:0]  ram [0:2047];
   logic        bd_we = 1'b0;
   logic [10:0] bd_idx = '0;
   logic [7:0]  bd_data = '0;

   function automatic logic [10:0] ridx(input logic [15:0] a);
      return {a[15:14], a[8:0]};
   endfunction

   function automatic logic [7:0] init_val(input logic [10:0] i);
      return 8'((32'(i) * 7) + 27);
   endfunction

   assign mem_rdata = ram[ridx(mem_addr)];

   always @(posedge clk) begin
      if (mem_we) ram[ridx(mem_addr)] <= mem_wdata;
      else if (bd_we) ram[bd_idx] <= bd_data;
   end

   // Reference model: expected memory contents and per-master last read value.
   logic [7:0] shadow [logic [15:0]];
   logic [7:0] last_rd [2];
   logic [8:0] exp_cpu [$];
   logic [8:0] exp_dbg [$];
   bit         exp_order [$];
   bit         chk_order = 1'b0;
   logic       hold_at_edge = 1'b0;
   logic       rst_at_edge = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [15:0] a);
      return shadow.exists(a) ? shadow[a] : init_val(ridx(a));
   endfunction

   function automatic void model_issue(input bit is_dbg, input bit we, input logic [15:0] a,
                                       input logic [7:0] d);
      bit oor;
      oor = RC && a[15];
      if (we) begin
         if (!oor) shadow[a] = d;
      end else begin
         last_rd[is_dbg] = oor ? 8'h00 : model_read(a);
      end
      if (is_dbg) exp_dbg.push_back({oor, last_rd[1]});
      else        exp_cpu.push_back({1'b0, last_rd[0]});
   endfunction

   always @(posedge clk) begin
      hold_at_edge <= dbg_hold;
      rst_at_edge  <= reset;
   end

   // Monitor: pops the scoreboard whenever an ack appears and checks bus invariants.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst_at_edge) begin
         chk("oe_we_exclusive", 32'(mem_oe & mem_we), 32'd0);
         chk("ack_exclusive", 32'(cpu_ack & dbg_ack), 32'd0);
         chk("cpu_stall_follow", 32'(cpu_stall), 32'(hold_at_edge));
         if (cpu_ack) begin
            if (exp_cpu.size() == 0) chk("cpu_ack_unexpected", 32'(cpu_ack), 32'd0);
            else begin
               e = exp_cpu.pop_front();
               chk("cpu_rdata", 32'(cpu_rdata), 32'(e[7:0]));
            end
         end
         if (dbg_ack) begin
            if (exp_dbg.size() == 0) chk("dbg_ack_unexpected", 32'(dbg_ack), 32'd0);
            else begin
               e = exp_dbg.pop_front();
               chk("dbg_rdata", 32'(dbg_rdata), 32'(e[7:0]));
               chk("dbg_err", 32'(dbg_err), 32'(e[8]));
            end
         end
         if (chk_order && (cpu_ack || dbg_ack)) begin
            if (exp_order.size() == 0) chk("grant_extra", 32'(cpu_ack | dbg_ack), 32'd0);
            else chk("grant_owner", 32'(dbg_ack), 32'(exp_order.pop_front()));
         end
      end
   end

   task automatic set_req(input bit is_dbg, input bit r, input bit we, input logic [15:0] a,
                          input logic [7:0] d);
      if (is_dbg) begin dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
      else        begin cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
   endtask

   // Single-requester access from IDLE with exact cycle-timing checks; entered at a negedge.
   task automatic directed_access(input bit is_dbg, input bit we, input logic [15:0] a,
                                  input logic [7:0] d);
      bit oor;
      oor = RC && a[15];
      model_issue(is_dbg, we, a, d);
      set_req(is_dbg, 1'b1, we, a, d);
      @(posedge clk);
      @(negedge clk);
      chk("acc_mem_addr", 32'(mem_addr), 32'(a));
      chk("acc_mem_oe", 32'(mem_oe), 32'(!we && !oor));
      chk("acc_mem_we", 32'(mem_we), 32'(we && !oor));
      if (we && !oor) chk("acc_mem_wdata", 32'(mem_wdata), 32'(d));
      chk("acc_no_ack", 32'(cpu_ack | dbg_ack), 32'd0);
      @(negedge clk);
      chk("resp_ack", 32'(is_dbg ? dbg_ack : cpu_ack), 32'd1);
      chk("resp_bus_idle", 32'(mem_oe | mem_we), 32'd0);
      set_req(is_dbg, 1'b0, we, a, d);
      repeat (2) @(negedge clk);
   endtask

   // Free-running access for random traffic; returns at the negedge of the ack cycle.
   task automatic bus_access(input bit is_dbg, input bit we, input logic [15:0] a,
                             input logic [7:0] d);
      int  n;
      bit  got;
      model_issue(is_dbg, we, a, d);
      set_req(is_dbg, 1'b1, we, a, d);
      n   = 0;
      got = 1'b0;
      while (!got && n < 100) begin
         @(negedge clk);
         n++;
         got = is_dbg ? dbg_ack : cpu_ack;
      end
      chk(is_dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", 32'(got), 32'd1);
      set_req(is_dbg, 1'b0, we, a, d);
   endtask

   task automatic preload(input logic [15:0] a, input logic [7:0] v);
      bd_we = 1'b1; bd_idx = ridx(a); bd_data = v;
      shadow[a] = v;
      @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      int run, acks, n;
      last_rd[0] = 8'h00;
      last_rd[1] = 8'h00;
      @(negedge clk);
      for (int i = 0; i < 2048; i++) begin
         bd_we = 1'b1; bd_idx = 11'(i); bd_data = init_val(11'(i));
         @(negedge clk);
      end
      preload(16'h0000, 8'hA5);
      preload(16'h0010, 8'h00);
      preload(16'h8000, 8'h3C);
      bd_we = 1'b0;
      @(negedge clk);

      chk("rst_mem_oe", 32'(mem_oe), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
      chk("rst_dbg_err", 32'(dbg_err), 32'd0);
      chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      chk("rst_dbg_rdata", 32'(dbg_rdata), 32'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      directed_access(1'b1, 1'b1, 16'h0002, 8'h25);
      directed_access(1'b1, 1'b0, 16'h0002, 8'h00);
      directed_access(1'b0, 1'b0, 16'h0000, 8'h00);

      // Contention: expected order from the burst rule, both requests held.
      run = 0;
      for (int i = 0; i < 10; i++) begin
         if (run < int'(MAXB)) begin
            exp_order.push_back(1'b1);
            model_issue(1'b1, 1'b0, 16'h4000, 8'h00);
            run++;
         end else begin
            exp_order.push_back(1'b0);
            model_issue(1'b0, 1'b0, 16'h0000, 8'h00);
            run = 0;
         end
      end
      chk_order = 1'b1;
      set_req(1'b1, 1'b1, 1'b0, 16'h4000, 8'h00);
      set_req(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00);
      acks = 0;
      n    = 0;
      while (acks < 10 && n < 200) begin
         @(negedge clk);
         n++;
         if (cpu_ack || dbg_ack) acks++;
      end
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      chk("contention_acks", 32'(acks), 32'd10);
      repeat (3) @(negedge clk);
      chk_order = 1'b0;
      chk("order_drained", 32'(exp_order.size()), 32'd0);

      // Pause: stall follows hold by one cycle while a CPU read still completes.
      dbg_hold = 1'b1;
      @(negedge clk);
      chk("stall_rise", 32'(cpu_stall), 32'd1);
      directed_access(1'b0, 1'b0, 16'h0000, 8'h00);
      dbg_hold = 1'b0;
      @(negedge clk);
      chk("stall_fall", 32'(cpu_stall), 32'd0);

      // Reset while a CPU write is in its access cycle.
      set_req(1'b0, 1'b1, 1'b1, 16'h0010, 8'h55);
      @(posedge clk);
      @(negedge clk);
      chk("rstacc_mem_we_before", 32'(mem_we), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("rstacc_mem_we", 32'(mem_we), 32'd0);
      chk("rstacc_mem_oe", 32'(mem_oe), 32'd0);
      chk("rstacc_cpu_ack", 32'(cpu_ack), 32'd0);
      set_req(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      last_rd[0] = 8'h00;
      last_rd[1] = 8'h00;
      @(negedge clk);
      reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("rstacc_no_ack", 32'(cpu_ack), 32'd0);
      end

      directed_access(1'b1, 1'b0, 16'h8000, 8'h00);

      // Random two-master traffic with hold toggling.
      fork
         for (int i = 0; i < 25; i++) begin
            bus_access(1'b0, 1'($urandom_range(0, 1)), 16'h0100 | 16'($urandom_range(0, 255)),
                       8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 5) == 0)
               bus_access(1'b1, 1'($urandom_range(0, 1)), 16'h8000 | 16'($urandom_range(0, 255)),
                          8'($urandom));
            else
               bus_access(1'b1, 1'($urandom_range(0, 1)), 16'h4000 | 16'($urandom_range(0, 255)),
                          8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         begin
            repeat (150) begin
               @(negedge clk);
               if ($urandom_range(0, 9) == 0) dbg_hold = ~dbg_hold;
            end
            dbg_hold = 1'b0;
         end
      join

      repeat (5) @(negedge clk);
      chk("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
      chk("dbg_queue_drained", 32'(exp_dbg.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
